// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA timing constants. The 640x480@60 set is the default geometry
// of vga_timing_gen; the 800x600@60 set is kept for later use.
// No ports; constants, a geometry struct and a helper function only.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned display;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_axis_t;

    function automatic int unsigned axis_total(input vga_axis_t a);
        return a.display + a.front + a.sync + a.back;
    endfunction

    // 640x480 @ 60 Hz, 25 MHz pixel clock
    localparam int VGA640_H_DISPLAY = 640;
    localparam int VGA640_H_FRONT   = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BACK    = 48;
    localparam int VGA640_V_DISPLAY = 480;
    localparam int VGA640_V_FRONT   = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BACK    = 33;

    localparam vga_axis_t VGA640_H = '{VGA640_H_DISPLAY, VGA640_H_FRONT,
                                       VGA640_H_SYNC, VGA640_H_BACK};
    localparam vga_axis_t VGA640_V = '{VGA640_V_DISPLAY, VGA640_V_FRONT,
                                       VGA640_V_SYNC, VGA640_V_BACK};
    localparam int VGA640_H_TOTAL = axis_total(VGA640_H);   // 800
    localparam int VGA640_V_TOTAL = axis_total(VGA640_V);   // 525

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA800_H_DISPLAY = 800;
    localparam int SVGA800_H_FRONT   = 40;
    localparam int SVGA800_H_SYNC    = 128;
    localparam int SVGA800_H_BACK    = 88;
    localparam int SVGA800_V_DISPLAY = 600;
    localparam int SVGA800_V_FRONT   = 1;
    localparam int SVGA800_V_SYNC    = 4;
    localparam int SVGA800_V_BACK    = 23;

    localparam vga_axis_t SVGA800_H = '{SVGA800_H_DISPLAY, SVGA800_H_FRONT,
                                        SVGA800_H_SYNC, SVGA800_H_BACK};
    localparam vga_axis_t SVGA800_V = '{SVGA800_V_DISPLAY, SVGA800_V_FRONT,
                                        SVGA800_V_SYNC, SVGA800_V_BACK};
    localparam int SVGA800_H_TOTAL = axis_total(SVGA800_H);  // 1056
    localparam int SVGA800_V_TOTAL = axis_total(SVGA800_V);  // 628

endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick
// Divides the system clock by PIX_DIV into a one-clk pixel strobe.
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   pix_tick out  high on the clk where div_cnt == PIX_DIV-1
module vga_pix_tick #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);

    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                div_cnt <= '0;
        else if (div_cnt == D_LAST) div_cnt <= '0;
        else                       div_cnt <= div_cnt + 1'b1;
    end

    // Gated by reset so that PIX_DIV=1 (div_cnt stuck at 0) does not strobe
    // while the block is held in reset.
    assign pix_tick = reset & (div_cnt == D_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA timing generator with a registered, blanked colour stage.
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   rgb_in     in   colour for the current pixel_x/pixel_y
//   hsync      out  horizontal sync, registered, polarity HS_POL
//   vsync      out  vertical sync, registered, polarity VS_POL
//   rgb        out  blanked colour, registered
//   pixel_x    out  horizontal counter
//   pixel_y    out  vertical counter
//   video_on   out  counters inside the visible area (combinational)
//   pix_tick   out  one-clk strobe per pixel
//   line_tick  out  pix_tick on which pixel_x wraps
//   frame_tick out  pix_tick on which both counters wrap
// hsync/vsync/rgb describe the pixel the counters just left, so all three
// stay aligned with each other one pixel behind pixel_x/pixel_y.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA640_H_DISPLAY,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int V_DISPLAY = VGA640_V_DISPLAY,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter int PIX_DIV   = 4,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int COLOR_W   = 3,
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int XW       = $clog2(H_TOTAL),
    localparam int YW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] rgb_in,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rgb,
    output logic [XW-1:0]      pixel_x,
    output logic [YW-1:0]      pixel_y,
    output logic               video_on,
    output logic               pix_tick,
    output logic               line_tick,
    output logic               frame_tick
);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_DISP   = XW'(H_DISPLAY);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_DISPLAY + H_FRONT);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_DISP   = YW'(V_DISPLAY);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_DISPLAY + V_FRONT);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic x_wrap;
    logic y_wrap;
    logic hs_act;
    logic vs_act;

    vga_pix_tick #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_tick (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pix_tick)
    );

    assign x_wrap = (pixel_x == X_LAST);
    assign y_wrap = (pixel_y == Y_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (pix_tick) begin
            if (x_wrap) begin
                pixel_x <= '0;
                pixel_y <= y_wrap ? '0 : pixel_y + 1'b1;
            end else begin
                pixel_x <= pixel_x + 1'b1;
            end
        end
    end

    assign video_on   = (pixel_x < X_DISP) && (pixel_y < Y_DISP);
    assign hs_act     = (pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST);
    assign vs_act     = (pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST);
    assign line_tick  = pix_tick & x_wrap;
    assign frame_tick = line_tick & y_wrap;

    // Output stage samples on the same edge that advances the counters, so
    // rgb_in only has to be valid for the clk carrying pix_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            rgb   <= '0;
        end else if (pix_tick) begin
            hsync <= hs_act ? HS_POL : ~HS_POL;
            vsync <= vs_act ? VS_POL : ~VS_POL;
            rgb   <= video_on ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Two instances on a reduced geometry (15x8 total): one with PIX_DIV=4,
// active-low syncs and 3-bit colour; one with PIX_DIV=1, active-high syncs
// and 8-bit colour. A per-instance reference model tracks the counters;
// the expected registered outputs for each pixel go into a scoreboard queue
// on pix_tick and are retired on the following edge.
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VD = 4, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HD + HF + HSW + HB;
    localparam int VT = VD + VF + VSW + VB;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam int FRAME_A = HT * VT * 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    a_rgb_in, a_rgb;
    logic [7:0]    b_rgb_in, b_rgb;
    logic [XW-1:0] a_px, b_px;
    logic [YW-1:0] a_py, b_py;
    logic a_hs, a_vs, a_von, a_pt, a_lt, a_ft;
    logic b_hs, b_vs, b_von, b_pt, b_lt, b_ft;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .PIX_DIV(4), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(3)
    ) u_a (
        .clk(clk), .reset(reset), .rgb_in(a_rgb_in),
        .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb),
        .pixel_x(a_px), .pixel_y(a_py), .video_on(a_von),
        .pix_tick(a_pt), .line_tick(a_lt), .frame_tick(a_ft)
    );

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .PIX_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8)
    ) u_b (
        .clk(clk), .reset(reset), .rgb_in(b_rgb_in),
        .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb),
        .pixel_x(b_px), .pixel_y(b_py), .video_on(b_von),
        .pix_tick(b_pt), .line_tick(b_lt), .frame_tick(b_ft)
    );

    typedef struct {
        int         d;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } exp_t;

    exp_t sbq[$];

    int n_chk = 0;
    int n_fail = 0;
    logic rnd_mode = 1'b0;

    int         m_div[2], m_x[2], m_y[2];
    logic       m_hs[2], m_vs[2];
    logic [7:0] m_rgb[2];
    int         l_cnt[2], l_hs[2], f_cnt[2], f_vs[2];
    bit         l_seen[2], f_seen[2];

    function automatic int pd(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic pol(input int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_rst(input int d);
        m_div[d] = 0; m_x[d] = 0; m_y[d] = 0;
        m_hs[d] = ~pol(d); m_vs[d] = ~pol(d); m_rgb[d] = 8'h0;
        l_seen[d] = 1'b0; f_seen[d] = 1'b0;
    endtask

    task automatic advance(input int d);
        if (!reset) begin
            model_rst(d);
        end else if (m_div[d] == pd(d) - 1) begin
            m_div[d] = 0;
            if (m_x[d] == HT - 1) begin
                m_x[d] = 0;
                m_y[d] = (m_y[d] == VT - 1) ? 0 : m_y[d] + 1;
            end else begin
                m_x[d]++;
            end
        end else begin
            m_div[d]++;
        end
    endtask

    task automatic check_dut(input int d);
        logic [31:0] px, py;
        logic von, pt, lt, ft, hs, vs, tk, lt_e, ft_e, von_e, hs_a, vs_a;
        logic [7:0] rg, ri;
        string p;
        exp_t e;
        if (d == 0) begin
            p = "a."; px = 32'(a_px); py = 32'(a_py); von = a_von; pt = a_pt;
            lt = a_lt; ft = a_ft; hs = a_hs; vs = a_vs;
            rg = {5'b0, a_rgb}; ri = {5'b0, a_rgb_in};
        end else begin
            p = "b."; px = 32'(b_px); py = 32'(b_py); von = b_von; pt = b_pt;
            lt = b_lt; ft = b_ft; hs = b_hs; vs = b_vs;
            rg = b_rgb; ri = b_rgb_in;
        end
        tk    = reset && (m_div[d] == pd(d) - 1);
        lt_e  = tk && (m_x[d] == HT - 1);
        ft_e  = lt_e && (m_y[d] == VT - 1);
        von_e = (m_x[d] < HD) && (m_y[d] < VD);
        chk({p, "pixel_x"},    px,        32'(m_x[d]));
        chk({p, "pixel_y"},    py,        32'(m_y[d]));
        chk({p, "video_on"},   32'(von),  32'(von_e));
        chk({p, "pix_tick"},   32'(pt),   32'(tk));
        chk({p, "line_tick"},  32'(lt),   32'(lt_e));
        chk({p, "frame_tick"}, 32'(ft),   32'(ft_e));
        chk({p, "hsync"},      32'(hs),   32'(m_hs[d]));
        chk({p, "vsync"},      32'(vs),   32'(m_vs[d]));
        chk({p, "rgb"},        32'(rg),   32'(m_rgb[d]));
        if (tk) begin
            hs_a  = (m_x[d] >= HD + HF) && (m_x[d] <= HD + HF + HSW - 1);
            vs_a  = (m_y[d] >= VD + VF) && (m_y[d] <= VD + VF + VSW - 1);
            e.d   = d;
            e.hs  = hs_a ? pol(d) : ~pol(d);
            e.vs  = vs_a ? pol(d) : ~pol(d);
            e.rgb = von_e ? ri : 8'h0;
            sbq.push_back(e);
        end
        // Period and pulse-width measurements, windowed on the DUT strobes.
        if (!reset) begin
            l_seen[d] = 1'b0; f_seen[d] = 1'b0;
        end else begin
            if (lt) begin
                if (l_seen[d]) begin
                    chk({p, "line_period"}, 32'(l_cnt[d]), 32'(HT * pd(d)));
                    chk({p, "hsync_width"}, 32'(l_hs[d]),  32'(HSW * pd(d)));
                end
                l_seen[d] = 1'b1; l_cnt[d] = 0; l_hs[d] = 0;
            end
            if (ft) begin
                if (f_seen[d]) begin
                    chk({p, "frame_period"}, 32'(f_cnt[d]), 32'(HT * VT * pd(d)));
                    chk({p, "vsync_width"},  32'(f_vs[d]),  32'(VSW * HT * pd(d)));
                end
                f_seen[d] = 1'b1; f_cnt[d] = 0; f_vs[d] = 0;
            end
            l_cnt[d]++; f_cnt[d]++;
            if (hs == pol(d)) l_hs[d]++;
            if (vs == pol(d)) f_vs[d]++;
        end
    endtask

    // One clk: drive colour, check at negedge, advance model after posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rnd_mode) begin
            a_rgb_in = 3'($urandom);
            b_rgb_in = 8'($urandom);
        end else begin
            a_rgb_in = 3'b101;
            b_rgb_in = 8'hA5;
        end
        #1;
        for (int d = 0; d < 2; d++) check_dut(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) advance(d);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            m_hs[e.d]  = e.hs;
            m_vs[e.d]  = e.vs;
            m_rgb[e.d] = e.rgb;
        end
    endtask

    initial begin
        bit hit;
        a_rgb_in = 3'b111;
        b_rgb_in = 8'hFF;
        model_rst(0);
        model_rst(1);
        sbq.delete();

        // Reset hold with all-ones colour
        #100;
        @(negedge clk);
        chk("rst.a.hsync",  32'(a_hs),  32'd1);
        chk("rst.a.vsync",  32'(a_vs),  32'd1);
        chk("rst.a.rgb",    32'(a_rgb), 32'd0);
        chk("rst.a.px",     32'(a_px),  32'd0);
        chk("rst.a.py",     32'(a_py),  32'd0);
        chk("rst.a.ticks",  32'({a_pt, a_lt, a_ft}), 32'd0);
        chk("rst.b.hsync",  32'(b_hs),  32'd0);
        chk("rst.b.vsync",  32'(b_vs),  32'd0);
        chk("rst.b.rgb",    32'(b_rgb), 32'd0);
        chk("rst.b.ticks",  32'({b_pt, b_lt, b_ft}), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Constant colour: blanking visible against a fixed non-zero value
        repeat (2 * FRAME_A) step();

        // Colour changing every clk: only the pix_tick sample may land
        rnd_mode = 1'b1;
        repeat (2 * FRAME_A) step();

        // Reset asserted mid-frame at (5,2) of instance a
        hit = 1'b0;
        for (int i = 0; i < FRAME_A && !hit; i++) begin
            step();
            if (a_py == 3'd2 && a_px == 4'd5) hit = 1'b1;
        end
        chk("mid.reached", 32'(hit), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid.a.px",    32'(a_px),  32'd0);
        chk("mid.a.py",    32'(a_py),  32'd0);
        chk("mid.a.hsync", 32'(a_hs),  32'd1);
        chk("mid.a.vsync", 32'(a_vs),  32'd1);
        chk("mid.a.rgb",   32'(a_rgb), 32'd0);
        chk("mid.a.ticks", 32'({a_pt, a_lt, a_ft}), 32'd0);
        chk("mid.b.px",    32'(b_px),  32'd0);
        chk("mid.b.hsync", 32'(b_hs),  32'd0);
        chk("mid.b.ticks", 32'({b_pt, b_lt, b_ft}), 32'd0);
        model_rst(0);
        model_rst(1);
        sbq.delete();
        repeat (5) step();
        #1 reset = 1'b1;

        // Restart from (0,0) and run three more frames
        repeat (3 * FRAME_A) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
